// File: rtl/ram_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_bist_pkg
// Desc     : Shared definitions for the March C- RAM self-test engine: FSM
//            state encoding, march element indices, per-element attributes
//            and the data backgrounds.
// Revision : 1.0 - initial release
// ============================================================================
package ram_bist_pkg;

    // FSM state encoding
    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_wr   = 3'd1;
    localparam logic [2:0] c_st_rd   = 3'd2;
    localparam logic [2:0] c_st_chk  = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    // March element indices
    localparam logic [2:0] c_e0 = 3'd0;
    localparam logic [2:0] c_e1 = 3'd1;
    localparam logic [2:0] c_e2 = 3'd2;
    localparam logic [2:0] c_e3 = 3'd3;
    localparam logic [2:0] c_e4 = 3'd4;
    localparam logic [2:0] c_e5 = 3'd5;

    // Backgrounds at the widest supported word; users slice to DATA_WIDTH
    localparam logic [63:0] c_d0_wide = 64'h0000_0000_0000_0000;
    localparam logic [63:0] c_d1_wide = 64'hFFFF_FFFF_FFFF_FFFF;

    // down    : element walks N-1 .. 0
    // has_wr  : element writes after its read (or, for E0, only writes)
    // exp_one : expected read background is D1
    // wr_one  : written background is D1
    typedef struct packed {
        logic down;
        logic has_wr;
        logic exp_one;
        logic wr_one;
    } elem_attr_t;

    // Descending elements are E3 and E4 only
    function automatic logic elem_is_down(input logic [2:0] elem);
        return (elem == c_e3) || (elem == c_e4);
    endfunction

    // E0 w0; E1 r0,w1; E2 r1,w0; E3 r0,w1; E4 r1,w0; E5 r0
    function automatic elem_attr_t elem_attr(input logic [2:0] elem);
        elem_attr_t attr;
        attr = '0;
        attr.down = elem_is_down(elem);
        case (elem)
            c_e0: begin attr.has_wr = 1'b1; attr.exp_one = 1'b0; attr.wr_one = 1'b0; end
            c_e1: begin attr.has_wr = 1'b1; attr.exp_one = 1'b0; attr.wr_one = 1'b1; end
            c_e2: begin attr.has_wr = 1'b1; attr.exp_one = 1'b1; attr.wr_one = 1'b0; end
            c_e3: begin attr.has_wr = 1'b1; attr.exp_one = 1'b0; attr.wr_one = 1'b1; end
            c_e4: begin attr.has_wr = 1'b1; attr.exp_one = 1'b1; attr.wr_one = 1'b0; end
            c_e5: begin attr.has_wr = 1'b0; attr.exp_one = 1'b0; attr.wr_one = 1'b0; end
            default: attr = '0;
        endcase
        return attr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_bist_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : ram_bist_addr_gen
// Desc     : Up/down address counter for the march engine. Loads 0 or N-1,
//            steps modulo N, and flags the last address of the current
//            direction with an exact compare.
// Revision : 1.0 - initial release
// ============================================================================
module ram_bist_addr_gen #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_load_high,
    input  logic                  i_step,
    input  logic                  i_down,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    localparam logic [ADDR_WIDTH-1:0] c_addr_max = '1;
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_addr;

    // Load has priority over step; arithmetic wraps naturally at the width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_high ? c_addr_max : '0;
        end else if (i_step) begin
            r_addr <= i_down ? (r_addr - c_addr_one) : (r_addr + c_addr_one);
        end
    end

    assign o_addr = r_addr;
    assign o_last = i_down ? (r_addr == '0) : (r_addr == c_addr_max);

endmodule
`default_nettype wire

// File: rtl/ram_bist.sv
`default_nettype none
// ============================================================================
// Module   : ram_bist
// Desc     : March C- built-in self-test engine for a single-port RAM with a
//            registered read. Owns the RAM port while busy and reports the
//            first mismatch (address, data read, element).
// Revision : 1.0 - initial release
// ============================================================================
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [2:0]            fail_elem,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [DATA_WIDTH-1:0] c_d0 = c_d0_wide[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] c_d1 = c_d1_wide[DATA_WIDTH-1:0];

    logic [2:0]            r_state;
    logic [2:0]            r_elem;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [DATA_WIDTH-1:0] r_fail_data;
    logic [2:0]            r_fail_elem;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;

    elem_attr_t            w_attr;
    logic [2:0]            w_next_elem;
    logic [DATA_WIDTH-1:0] w_exp;
    logic                  w_mismatch;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_last;
    logic                  w_load;
    logic                  w_load_high;
    logic                  w_step;

    assign w_attr      = elem_attr(r_elem);
    assign w_next_elem = r_elem + 3'd1;
    assign w_exp       = w_attr.exp_one ? c_d1 : c_d0;
    assign w_mismatch  = (r_state == c_st_chk) && (ram_rdata != w_exp);

    ram_bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_load_high (w_load_high),
        .i_step      (w_step),
        .i_down      (w_attr.down),
        .o_addr      (w_addr),
        .o_last      (w_last)
    );

    // Address counter control: load element start addresses, step otherwise
    always_comb begin
        w_load      = 1'b0;
        w_load_high = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            c_st_idle, c_st_done: begin
                w_load = start;
            end
            c_st_wr: begin
                if (w_last) begin
                    w_load      = 1'b1;
                    w_load_high = elem_is_down(w_next_elem);
                end else begin
                    w_step = 1'b1;
                end
            end
            c_st_chk: begin
                if (!w_mismatch) begin
                    if (!w_last) begin
                        w_step = 1'b1;
                    end else if (r_elem != c_e5) begin
                        w_load      = 1'b1;
                        w_load_high = elem_is_down(w_next_elem);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // March sequencer: state, element, RAM strobes and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_elem      <= c_e0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_fail_elem <= 3'd0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_state     <= c_st_wr;
                        r_elem      <= c_e0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail_addr <= '0;
                        r_fail_data <= '0;
                        r_fail_elem <= 3'd0;
                        r_we        <= 1'b1;
                        r_wdata     <= c_d0;
                    end
                end
                c_st_wr: begin
                    if (w_last) begin
                        r_state <= c_st_rd;
                        r_elem  <= w_next_elem;
                        r_we    <= 1'b0;
                    end else begin
                        r_we    <= 1'b1;
                        r_wdata <= w_attr.wr_one ? c_d1 : c_d0;
                    end
                end
                c_st_rd: begin
                    // The complementary write is staged for the CHK cycle
                    r_state <= c_st_chk;
                    r_we    <= w_attr.has_wr;
                    r_wdata <= w_attr.wr_one ? c_d1 : c_d0;
                end
                c_st_chk: begin
                    r_we <= 1'b0;
                    if (w_mismatch) begin
                        r_state     <= c_st_done;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_fail_addr <= w_addr;
                        r_fail_data <= ram_rdata;
                        r_fail_elem <= r_elem;
                    end else if (w_last && (r_elem == c_e5)) begin
                        r_state <= c_st_done;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b1;
                    end else begin
                        r_state <= c_st_rd;
                        if (w_last) begin
                            r_elem <= w_next_elem;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;
    assign fail_elem = r_fail_elem;
    assign ram_addr  = w_addr;
    assign ram_wdata = r_wdata;
    // A CHK write is staged a cycle early; the live compare vetoes it so a
    // failing word is never overwritten.
    assign ram_we    = r_we & ~w_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_ram_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_bist
// Desc     : Self-checking bench for ram_bist with a behavioural RAM, a
//            read-path stuck-at fault injector and a march reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_bist;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int N   = 1 << AW;
    localparam int MAX = 11 * N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [2:0]    fail_elem;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    ram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .fail_elem (fail_elem),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Fault configuration
    logic          fault_en;
    logic [AW-1:0] fault_addr;
    int            fault_bit;
    logic          fault_val;

    function automatic logic [DW-1:0] apply_fault(input logic [DW-1:0] d, input logic [AW-1:0] a,
                                                  input logic en, input logic [AW-1:0] fa,
                                                  input int fb, input logic fv);
        logic [DW-1:0] m;
        m = {{(DW-1){1'b0}}, 1'b1} << fb;
        if (en && (a == fa)) return fv ? (d | m) : (d & ~m);
        return d;
    endfunction

    // Behavioural single-port RAM with registered read
    logic [DW-1:0] mem [N];
    logic [DW-1:0] rd_q;
    logic [AW-1:0] rd_addr_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rd_q      <= mem[ram_addr];
        rd_addr_q <= ram_addr;
    end
    assign ram_rdata = apply_fault(rd_q, rd_addr_q, fault_en, fault_addr, fault_bit, fault_val);

    // Reference: expected per-cycle RAM operations and final verdict
    logic          op_we   [MAX];
    logic [AW-1:0] op_addr [MAX];
    logic [DW-1:0] op_wd   [MAX];
    int            n_ops;
    logic          exp_pass;
    logic [AW-1:0] exp_faddr;
    logic [DW-1:0] exp_fdata;
    logic [2:0]    exp_felem;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d] actual=0x%0h required=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic push(input logic we, input int a, input logic [DW-1:0] wd);
        op_we[n_ops]   = we;
        op_addr[n_ops] = AW'(a);
        op_wd[n_ops]   = wd;
        n_ops++;
    endtask

    // Walk the march abstractly over a model memory seen through the fault
    task automatic build_model();
        logic [DW-1:0] mm [N];
        logic [DW-1:0] bg;
        logic [DW-1:0] rv;
        int a;
        bit down;
        bit wr;
        n_ops = 0; exp_pass = 1'b1; exp_faddr = '0; exp_fdata = '0; exp_felem = '0;
        for (int i = 0; i < N; i++) begin
            push(1'b1, i, '0);
            mm[i] = '0;
        end
        for (int e = 1; e <= 5; e++) begin
            bg   = (e == 2 || e == 4) ? '1 : '0;
            down = (e == 3 || e == 4);
            wr   = (e != 5);
            for (int i = 0; i < N; i++) begin
                a = down ? (N - 1 - i) : i;
                push(1'b0, a, '0);
                rv = apply_fault(mm[a], AW'(a), fault_en, fault_addr, fault_bit, fault_val);
                if (rv != bg) begin
                    push(1'b0, a, '0);
                    exp_pass = 1'b0; exp_faddr = AW'(a); exp_fdata = rv; exp_felem = 3'(e);
                    return;
                end
                push(wr, a, ~bg);
                if (wr) mm[a] = ~bg;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"},      0, 32'(busy),      0);
        chk({tag, "_done"},      0, 32'(done),      0);
        chk({tag, "_pass"},      0, 32'(pass),      0);
        chk({tag, "_fail_addr"}, 0, 32'(fail_addr), 0);
        chk({tag, "_fail_data"}, 0, 32'(fail_data), 0);
        chk({tag, "_fail_elem"}, 0, 32'(fail_elem), 0);
        chk({tag, "_ram_we"},    0, 32'(ram_we),    0);
        chk({tag, "_ram_addr"},  0, 32'(ram_addr),  0);
        chk({tag, "_ram_wdata"}, 0, 32'(ram_wdata), 0);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("idle_we",   i, 32'(ram_we), 0);
            chk("idle_busy", i, 32'(busy),   0);
        end
    endtask

    // Pulse start, then compare the DUT against the model every cycle.
    // restart_at: cycle at which start is re-pulsed (ignored if out of range)
    // reset_at  : cycle at which rst_n is pulsed low (-1 for none)
    task automatic run_test(input int restart_at, input int reset_at);
        build_model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= n_ops; k++) begin
            @(negedge clk);
            if (k == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_values("midreset");
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end
            if (k < n_ops) begin
                chk("busy",      k, 32'(busy),      1);
                chk("done",      k, 32'(done),      0);
                chk("pass",      k, 32'(pass),      0);
                chk("fail_addr", k, 32'(fail_addr), 0);
                chk("fail_data", k, 32'(fail_data), 0);
                chk("fail_elem", k, 32'(fail_elem), 0);
                chk("ram_we",    k, 32'(ram_we),    32'(op_we[k]));
                chk("ram_addr",  k, 32'(ram_addr),  32'(op_addr[k]));
                if (op_we[k]) chk("ram_wdata", k, 32'(ram_wdata), 32'(op_wd[k]));
            end else begin
                chk("end_busy",      k, 32'(busy),      0);
                chk("end_done",      k, 32'(done),      1);
                chk("end_pass",      k, 32'(pass),      32'(exp_pass));
                chk("end_fail_addr", k, 32'(fail_addr), 32'(exp_faddr));
                chk("end_fail_data", k, 32'(fail_data), 32'(exp_fdata));
                chk("end_fail_elem", k, 32'(fail_elem), 32'(exp_felem));
                chk("end_ram_we",    k, 32'(ram_we),    0);
            end
            start = (k == restart_at) && (k < n_ops);
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        fault_en = 1'b0; fault_addr = '0; fault_bit = 0; fault_val = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Pin the reference model with hand-derived values
        build_model();
        chk("model_len",      0,  n_ops, 176);
        chk("model_pass",     0,  32'(exp_pass), 1);
        chk("model_e3_rd",    80, 32'(op_addr[80]), 15);
        chk("model_e3_rd_we", 80, 32'(op_we[80]), 0);
        chk("model_e3_wr",    81, 32'(op_addr[81]), 15);
        chk("model_e3_wr_we", 81, 32'(op_we[81]), 1);
        chk("model_e3_wd",    81, 32'(op_wd[81]), 32'hFF);
        chk("model_e3_next",  82, 32'(op_addr[82]), 14);
        chk("model_e5_end",   175, 32'(op_addr[175]), 15);

        // Fault-free run with a mid-test start re-pulse
        idle(2);
        run_test(int'($urandom_range(1, 170)), -1);
        for (int i = 0; i < N; i++) chk("ram_final", i, 32'(mem[i]), 0);
        idle(2);

        // Stuck-at-1 on bit 0 of address 5
        fault_en = 1'b1; fault_addr = 4'd5; fault_bit = 0; fault_val = 1'b1;
        build_model();
        chk("model_sa1_elem", 0, 32'(exp_felem), 1);
        chk("model_sa1_addr", 0, 32'(exp_faddr), 5);
        chk("model_sa1_data", 0, 32'(exp_fdata), 32'h01);
        run_test(-1, -1);
        chk("sa1_pass", 0, 32'(pass),      0);
        chk("sa1_elem", 0, 32'(fail_elem), 1);
        chk("sa1_addr", 0, 32'(fail_addr), 5);
        chk("sa1_data", 0, 32'(fail_data), 32'h01);
        chk("sa1_mem5", 0, 32'(mem[5]),    0);
        idle(1);

        // Stuck-at-0 on bit 7 of address 15, started from a failed DONE
        fault_addr = 4'd15; fault_bit = 7; fault_val = 1'b0;
        build_model();
        chk("model_sa0_elem", 0, 32'(exp_felem), 2);
        chk("model_sa0_addr", 0, 32'(exp_faddr), 15);
        chk("model_sa0_data", 0, 32'(exp_fdata), 32'h7F);
        run_test(-1, -1);
        chk("sa0_elem", 0, 32'(fail_elem), 2);
        chk("sa0_addr", 0, 32'(fail_addr), 15);
        chk("sa0_data", 0, 32'(fail_data), 32'h7F);
        idle(1);

        // Fault released: rerun from DONE must clear fields and pass
        fault_en = 1'b0;
        run_test(-1, -1);
        chk("rerun_pass", 0, 32'(pass), 1);
        idle(1);

        // Asynchronous reset at cycle 90, then a full passing test
        run_test(-1, 90);
        idle(2);
        run_test(-1, -1);
        chk("post_reset_pass", 0, 32'(pass), 1);

        // Randomized stuck-at faults
        for (int r = 0; r < 4; r++) begin
            idle(int'($urandom_range(1, 4)));
            fault_en   = 1'b1;
            fault_addr = AW'($urandom_range(0, N - 1));
            fault_bit  = int'($urandom_range(0, DW - 1));
            fault_val  = 1'($urandom_range(0, 1));
            run_test(int'($urandom_range(1, 30)), -1);
        end
        fault_en = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
